// File: rtl/ahbl_dmac_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahbl_slv_if / ahbl_mst_if
//  Purpose  : AHB-Lite bus bundles used by the DMA controller.
//             ahbl_slv_if : register-access port (splitter -> DMA).
//               modport master : bus side (drives select/address/data).
//               modport slave  : DMA side (returns HREADYOUT/HRDATA).
//             ahbl_mst_if : DMA bus-master port plus arbiter request/grant.
//               modport master : DMA side (drives address/control/data).
//               modport slave  : fabric side (returns grant/ready/rdata).
//  Revision : 1.0  initial release
// ============================================================================
interface ahbl_slv_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
                  input  HREADYOUT, HRDATA);
  modport slave  (input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
                  output HREADYOUT, HRDATA);
endinterface

interface ahbl_mst_if;
  logic        HBUSREQ;
  logic        HGRANT;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  modport master (output HBUSREQ, HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
                  input  HGRANT, HREADY, HRDATA);
  modport slave  (input  HBUSREQ, HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
                  output HGRANT, HREADY, HRDATA);
endinterface
`default_nettype wire

// File: rtl/ahbl_dmac.sv
`default_nettype none
// ============================================================================
//  Module   : ahbl_dmac
//  Purpose  : Single-channel AHB-Lite DMA controller. Copies 32-bit words
//             from SRC to DST on its own master port, optionally paced by a
//             peripheral DREQ level, configured through an AHB-Lite slave.
//  Ports    : HCLK, HRESETn   clock / asynchronous active-low reset
//             s_ahb            register slave port (ahbl_slv_if.slave)
//             m_ahb            bus master port + HBUSREQ/HGRANT (ahbl_mst_if.master)
//             DREQ             peripheral data request (level)
//             IRQ              STATUS.DONE & CTRL.IRQ_EN
//  Registers: 0x00 SRC, 0x04 DST, 0x08 CTRL[4:0] = {IRQ_EN,DREQ_MODE,
//             DST_INC,SRC_INC,EN}, 0x0C COUNT, 0x10 STATUS = {DONE(W1C),BUSY}
//  Revision : 1.0  initial release
// ============================================================================
module ahbl_dmac #(
  parameter int CNT_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  ahbl_slv_if.slave   s_ahb,
  ahbl_mst_if.master  m_ahb,
  input  logic        DREQ,
  output logic        IRQ
);

  localparam logic [2:0] C_REG_SRC    = 3'd0;
  localparam logic [2:0] C_REG_DST    = 3'd1;
  localparam logic [2:0] C_REG_CTRL   = 3'd2;
  localparam logic [2:0] C_REG_COUNT  = 3'd3;
  localparam logic [2:0] C_REG_STATUS = 3'd4;
  localparam logic [1:0] C_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DREQ = 3'd1,
    ST_REQ       = 3'd2,
    ST_RD_A      = 3'd3,
    ST_RD_D      = 3'd4,
    ST_WR_A      = 3'd5,
    ST_WR_D      = 3'd6
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src, r_dst, r_buf;
  logic [4:0]       r_ctrl;
  logic [CNT_W-1:0] r_count;
  logic             r_busy, r_done;
  // registered master-port outputs
  logic [31:0]      r_haddr, r_hwdata;
  logic [1:0]       r_htrans;
  logic             r_hwrite, r_hbusreq;
  // slave data-phase context latched in the address phase
  logic             r_dp_valid, r_dp_write;
  logic [2:0]       r_dp_reg;

  logic             w_wr_commit;
  logic [31:0]      w_rdata, w_src_next, w_dst_next;
  logic [CNT_W-1:0] w_count_dec;
  logic             w_unused;

  assign w_wr_commit = r_dp_valid & r_dp_write & s_ahb.HREADY;
  assign w_count_dec = r_count - 1'b1;
  assign w_src_next  = r_src + (r_ctrl[1] ? 32'd4 : 32'd0);
  assign w_dst_next  = r_dst + (r_ctrl[2] ? 32'd4 : 32'd0);
  // only word accesses at a 32-byte register window are decoded
  assign w_unused    = ^{s_ahb.HSIZE, s_ahb.HADDR[31:5], s_ahb.HADDR[1:0]};

  always_comb begin
    w_rdata = 32'h0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_reg)
        C_REG_SRC:    w_rdata = r_src;
        C_REG_DST:    w_rdata = r_dst;
        C_REG_CTRL:   w_rdata = 32'(r_ctrl);
        C_REG_COUNT:  w_rdata = 32'(r_count);
        C_REG_STATUS: w_rdata = {30'h0, r_done, r_busy};
        default:      w_rdata = 32'h0;
      endcase
    end
  end

  assign s_ahb.HREADYOUT = 1'b1;
  assign s_ahb.HRDATA    = w_rdata;
  assign m_ahb.HBUSREQ   = r_hbusreq;
  assign m_ahb.HADDR     = r_haddr;
  assign m_ahb.HTRANS    = r_htrans;
  assign m_ahb.HSIZE     = 3'b010;
  assign m_ahb.HWRITE    = r_hwrite;
  assign m_ahb.HWDATA    = r_hwdata;
  assign IRQ             = r_done & r_ctrl[4];

  // Register file and transfer FSM share one block: FSM assignments come
  // after the CPU write decode so hardware updates (DONE set, EN clear)
  // take priority over a same-cycle register write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_src      <= 32'h0;
      r_dst      <= 32'h0;
      r_buf      <= 32'h0;
      r_ctrl     <= 5'h0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_haddr    <= 32'h0;
      r_hwdata   <= 32'h0;
      r_htrans   <= C_TRANS_IDLE;
      r_hwrite   <= 1'b0;
      r_hbusreq  <= 1'b0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_reg   <= 3'd0;
    end else begin
      if (s_ahb.HREADY) begin
        r_dp_valid <= s_ahb.HSEL & s_ahb.HTRANS[1];
        r_dp_write <= s_ahb.HWRITE;
        r_dp_reg   <= s_ahb.HADDR[4:2];
      end

      if (w_wr_commit) begin
        case (r_dp_reg)
          C_REG_SRC:   if (!r_busy) r_src <= s_ahb.HWDATA;
          C_REG_DST:   if (!r_busy) r_dst <= s_ahb.HWDATA;
          C_REG_COUNT: if (!r_busy) r_count <= s_ahb.HWDATA[CNT_W-1:0];
          C_REG_CTRL: begin
            if (r_busy) begin
              r_ctrl[0] <= s_ahb.HWDATA[0];
            end else begin
              r_ctrl <= s_ahb.HWDATA[4:0];
              r_busy <= s_ahb.HWDATA[0];
            end
          end
          C_REG_STATUS: if (s_ahb.HWDATA[1]) r_done <= 1'b0;
          default: ;
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (r_busy) begin
            if (r_count == '0) begin
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_ctrl[0] <= 1'b0;
            end else if (!r_ctrl[0]) begin
              r_busy <= 1'b0;
            end else if (r_ctrl[3]) begin
              r_state <= ST_WAIT_DREQ;
            end else begin
              r_state   <= ST_REQ;
              r_hbusreq <= 1'b1;
            end
          end
        end
        // No bus transfer is outstanding in these two states, so an EN
        // clear can abort immediately.
        ST_WAIT_DREQ: begin
          if (!r_ctrl[0]) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (DREQ) begin
            r_state   <= ST_REQ;
            r_hbusreq <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!r_ctrl[0]) begin
            r_busy    <= 1'b0;
            r_hbusreq <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (m_ahb.HGRANT) begin
            r_state  <= ST_RD_A;
            r_haddr  <= r_src;
            r_htrans <= C_TRANS_NONSEQ;
            r_hwrite <= 1'b0;
          end
        end
        ST_RD_A: begin
          if (m_ahb.HREADY) begin
            r_state  <= ST_RD_D;
            r_htrans <= C_TRANS_IDLE;
          end
        end
        ST_RD_D: begin
          if (m_ahb.HREADY) begin
            r_buf    <= m_ahb.HRDATA;
            r_state  <= ST_WR_A;
            r_haddr  <= r_dst;
            r_htrans <= C_TRANS_NONSEQ;
            r_hwrite <= 1'b1;
          end
        end
        ST_WR_A: begin
          if (m_ahb.HREADY) begin
            r_state  <= ST_WR_D;
            r_htrans <= C_TRANS_IDLE;
            r_hwdata <= r_buf;
          end
        end
        ST_WR_D: begin
          if (m_ahb.HREADY) begin
            r_count  <= w_count_dec;
            r_src    <= w_src_next;
            r_dst    <= w_dst_next;
            r_hwrite <= 1'b0;
            if (w_count_dec == '0) begin
              r_done    <= 1'b1;
              r_ctrl[0] <= 1'b0;
              r_busy    <= 1'b0;
              r_hbusreq <= 1'b0;
              r_state   <= ST_IDLE;
            end else if (!r_ctrl[0]) begin
              r_busy    <= 1'b0;
              r_hbusreq <= 1'b0;
              r_state   <= ST_IDLE;
            end else if (r_ctrl[3]) begin
              r_hbusreq <= 1'b0;
              r_state   <= ST_WAIT_DREQ;
            end else begin
              r_state  <= ST_RD_A;
              r_haddr  <= w_src_next;
              r_htrans <= C_TRANS_NONSEQ;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahbl_dmac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahbl_dmac
//  Purpose  : Directed self-checking bench for ahbl_dmac: register reset and
//             async reset mid-transfer, mem-to-mem copy with grant delay,
//             DONE/IRQ clear, DREQ pacing, zero-count start, wait states,
//             and abort via EN clear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahbl_dmac;

  localparam logic [31:0] BASE   = 32'h4001_0000;
  localparam logic [31:0] R_SRC  = BASE + 32'h00;
  localparam logic [31:0] R_DST  = BASE + 32'h04;
  localparam logic [31:0] R_CTRL = BASE + 32'h08;
  localparam logic [31:0] R_CNT  = BASE + 32'h0C;
  localparam logic [31:0] R_STAT = BASE + 32'h10;
  localparam logic [31:0] PERIPH = 32'h4040_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic dreq  = 1'b0;
  logic grant = 1'b1;
  logic irq;

  always #5 clk = ~clk;

  ahbl_slv_if s_bus ();
  ahbl_mst_if m_bus ();

  ahbl_dmac #(.CNT_W(16)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .s_ahb   (s_bus),
    .m_ahb   (m_bus),
    .DREQ    (dreq),
    .IRQ     (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- memory / peripheral model on the master port ----------
  logic [31:0] rmem [0:255];
  logic [31:0] wmem [0:255];
  int ns_cnt = 0;
  int wr_cnt = 0;
  int periph_cnt = 0;
  int rd_wait = 0;
  int wr_wait = 0;
  int wcnt;
  logic dp_valid, dp_write;
  logic [31:0] dp_addr, dp_rdata;

  assign m_bus.HGRANT = grant;
  assign m_bus.HREADY = !(dp_valid && wcnt != 0);
  assign m_bus.HRDATA = (dp_valid && !dp_write) ? dp_rdata : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
      dp_rdata <= 32'h0;
      wcnt     <= 0;
    end else if (dp_valid && wcnt != 0) begin
      wcnt <= wcnt - 1;
    end else begin
      if (dp_valid && dp_write) begin
        wmem[dp_addr[9:2]] <= m_bus.HWDATA;
        wr_cnt <= wr_cnt + 1;
      end
      dp_valid <= m_bus.HTRANS[1];
      dp_write <= m_bus.HWRITE;
      dp_addr  <= m_bus.HADDR;
      wcnt     <= m_bus.HTRANS[1] ? (m_bus.HWRITE ? wr_wait : rd_wait) : 0;
      if (m_bus.HTRANS[1]) begin
        ns_cnt <= ns_cnt + 1;
        if (!m_bus.HWRITE) begin
          if (m_bus.HADDR == PERIPH) begin
            dp_rdata   <= 32'h5A00_0000 + 32'(periph_cnt);
            periph_cnt <= periph_cnt + 1;
          end else begin
            dp_rdata <= rmem[m_bus.HADDR[9:2]];
          end
        end
      end
    end
  end

  // ---------------- CPU-side register access ------------------------------
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    s_bus.HSEL = 1'b1; s_bus.HADDR = addr; s_bus.HTRANS = 2'b10; s_bus.HWRITE = 1'b1;
    @(negedge clk);
    s_bus.HSEL = 1'b0; s_bus.HTRANS = 2'b00; s_bus.HWRITE = 1'b0; s_bus.HWDATA = data;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    s_bus.HSEL = 1'b1; s_bus.HADDR = addr; s_bus.HTRANS = 2'b10; s_bus.HWRITE = 1'b0;
    @(negedge clk);
    s_bus.HSEL = 1'b0; s_bus.HTRANS = 2'b00;
    data = s_bus.HRDATA;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    logic [31:0] rd;
    int n;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m_bus.HTRANS, m_bus.HBUSREQ, m_bus.HWRITE, irq, s_bus.HREADYOUT} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b exp=000001",
               {m_bus.HTRANS, m_bus.HBUSREQ, m_bus.HWRITE, irq, s_bus.HREADYOUT});
    end
    n_checks++;
    if ({m_bus.HADDR, m_bus.HWDATA, s_bus.HRDATA} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0", {m_bus.HADDR, m_bus.HWDATA, s_bus.HRDATA});
    end
    rst_n = 1'b1;
    // start a job, then pull reset while the first read address is out
    ahb_write(R_SRC, 32'h2000_0000);
    ahb_write(R_DST, 32'h2000_0100);
    ahb_write(R_CNT, 32'd4);
    ahb_write(R_CTRL, 32'h17);
    n = 0;
    while (!(m_bus.HTRANS == 2'b10 && !m_bus.HWRITE) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL reset_wait_rd_a got=timeout exp=RD_A");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_bus.HTRANS, m_bus.HBUSREQ, irq} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=0000", {m_bus.HTRANS, m_bus.HBUSREQ, irq});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ahb_read(BASE + 32'(i * 4), rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg%0d got=%h exp=0", i, rd);
      end
    end
    ahb_write(BASE + 32'h18, 32'hFFFF_FFFF);
    ahb_read(BASE + 32'h18, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read got=%h exp=0", rd);
    end
  endtask

  task automatic test_mem_copy();
    logic [31:0] rd;
    int ns0, wr0, n, cyc;
    logic [31:0] exp_words [0:3];
    exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33; exp_words[3] = 32'h44;
    grant = 1'b0;
    ahb_write(R_SRC, 32'h2000_0000);
    ahb_write(R_DST, 32'h2000_0100);
    ahb_write(R_CNT, 32'd4);
    ns0 = ns_cnt; wr0 = wr_cnt;
    ahb_write(R_CTRL, 32'h17);
    repeat (10) @(negedge clk);
    n_checks++;
    if (!(m_bus.HBUSREQ === 1'b1 && m_bus.HTRANS === 2'b00 && ns_cnt == ns0)) begin
      n_fail++;
      $display("FAIL copy_req_hold got=busreq%b trans%b ns%0d exp=busreq1 trans00 ns0",
               m_bus.HBUSREQ, m_bus.HTRANS, ns_cnt - ns0);
    end
    grant = 1'b1;
    n = 0;
    while (m_bus.HTRANS !== 2'b10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cyc = 0;
    while (irq !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL copy_cycles got=%0d exp=16", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wmem[64 + i] !== exp_words[i]) begin
        n_fail++;
        $display("FAIL copy_word%0d got=%h exp=%h", i, wmem[64 + i], exp_words[i]);
      end
    end
    ahb_read(R_STAT, rd);
    n_checks++;
    if (rd !== 32'h2 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL copy_status got=%h irq=%b exp=2 irq=1", rd, irq);
    end
    ahb_read(R_SRC, rd);
    n_checks++;
    if (rd !== 32'h2000_0010) begin
      n_fail++;
      $display("FAIL copy_src got=%h exp=20000010", rd);
    end
    ahb_read(R_DST, rd);
    n_checks++;
    if (rd !== 32'h2000_0110) begin
      n_fail++;
      $display("FAIL copy_dst got=%h exp=20000110", rd);
    end
    ahb_read(R_CTRL, rd);
    n_checks++;
    if (rd !== 32'h16) begin
      n_fail++;
      $display("FAIL copy_ctrl got=%h exp=16", rd);
    end
    n_checks++;
    if (ns_cnt - ns0 != 8 || wr_cnt - wr0 != 4) begin
      n_fail++;
      $display("FAIL copy_bus_count got=ns%0d wr%0d exp=ns8 wr4", ns_cnt - ns0, wr_cnt - wr0);
    end
  endtask

  task automatic test_irq_clear();
    logic [31:0] rd;
    ahb_write(R_STAT, 32'h2);
    ahb_read(R_STAT, rd);
    n_checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got=%h irq=%b exp=0 irq=0", rd, irq);
    end
  endtask

  task automatic test_dreq_mode();
    logic [31:0] rd;
    int ns0, p0;
    ahb_write(R_SRC, PERIPH);
    ahb_write(R_DST, 32'h2000_0200);
    ahb_write(R_CNT, 32'd3);
    ns0 = ns_cnt; p0 = periph_cnt;
    ahb_write(R_CTRL, 32'h0D);
    ahb_write(R_SRC, 32'h1234_5678);
    repeat (46) @(negedge clk);
    n_checks++;
    if (ns_cnt != ns0 || m_bus.HBUSREQ !== 1'b0) begin
      n_fail++;
      $display("FAIL dreq_idle got=ns%0d busreq%b exp=ns0 busreq0", ns_cnt - ns0, m_bus.HBUSREQ);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dreq = 1'b1;
      @(negedge clk); dreq = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++;
      if (m_bus.HBUSREQ !== 1'b0) begin
        n_fail++;
        $display("FAIL dreq_busreq_gap%0d got=%b exp=0", k, m_bus.HBUSREQ);
      end
      ahb_read(R_DST, rd);
      n_checks++;
      if (rd !== 32'h2000_0200 + 32'(4 * (k + 1))) begin
        n_fail++;
        $display("FAIL dreq_dst%0d got=%h exp=%h", k, rd, 32'h2000_0200 + 32'(4 * (k + 1)));
      end
      repeat (25) @(negedge clk);
    end
    n_checks++;
    if (periph_cnt - p0 != 3 || ns_cnt - ns0 != 6) begin
      n_fail++;
      $display("FAIL dreq_reads got=periph%0d ns%0d exp=periph3 ns6", periph_cnt - p0, ns_cnt - ns0);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wmem[128 + k] !== 32'h5A00_0000 + 32'(p0 + k)) begin
        n_fail++;
        $display("FAIL dreq_word%0d got=%h exp=%h", k, wmem[128 + k], 32'h5A00_0000 + 32'(p0 + k));
      end
    end
    ahb_read(R_SRC, rd);
    n_checks++;
    if (rd !== PERIPH) begin
      n_fail++;
      $display("FAIL dreq_src_fixed got=%h exp=%h", rd, PERIPH);
    end
    ahb_read(R_STAT, rd);
    n_checks++;
    if (rd !== 32'h2 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL dreq_status got=%h irq=%b exp=2 irq=0", rd, irq);
    end
  endtask

  task automatic test_count_zero();
    logic [31:0] rd;
    int ns0;
    ahb_write(R_STAT, 32'h2);
    ahb_write(R_CNT, 32'd0);
    ns0 = ns_cnt;
    ahb_write(R_CTRL, 32'h11);
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt0_irq got=%b exp=1", irq);
    end
    ahb_read(R_STAT, rd);
    n_checks++;
    if (rd !== 32'h2 || ns_cnt != ns0) begin
      n_fail++;
      $display("FAIL cnt0_status got=%h ns%0d exp=2 ns0", rd, ns_cnt - ns0);
    end
    ahb_read(R_CTRL, rd);
    n_checks++;
    if (rd !== 32'h10) begin
      n_fail++;
      $display("FAIL cnt0_ctrl got=%h exp=10", rd);
    end
  endtask

  task automatic test_wait_states();
    int n, cyc;
    ahb_write(R_STAT, 32'h2);
    rd_wait = 3; wr_wait = 2;
    ahb_write(R_SRC, 32'h2000_0020);
    ahb_write(R_DST, 32'h2000_0180);
    ahb_write(R_CNT, 32'd1);
    ahb_write(R_CTRL, 32'h17);
    n = 0;
    while (m_bus.HTRANS !== 2'b10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cyc = 0;
    while (irq !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 9) begin
      n_fail++;
      $display("FAIL wait_cycles got=%0d exp=9", cyc);
    end
    n_checks++;
    if (wmem[96] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wait_data got=%h exp=deadbeef", wmem[96]);
    end
    rd_wait = 0; wr_wait = 0;
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int wr0, ns0, n, rd_seen;
    ahb_write(R_STAT, 32'h2);
    ahb_write(R_SRC, 32'h2000_0000);
    ahb_write(R_DST, 32'h2000_0140);
    ahb_write(R_CNT, 32'd8);
    wr0 = wr_cnt; ns0 = ns_cnt;
    ahb_write(R_CTRL, 32'h07);
    rd_seen = 0; n = 0;
    while (rd_seen < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (m_bus.HTRANS === 2'b10 && m_bus.HWRITE === 1'b0) rd_seen++;
    end
    n_checks++;
    if (rd_seen != 3) begin
      n_fail++;
      $display("FAIL abort_find_word3 got=%0d exp=3", rd_seen);
    end
    // address phase of this write lands in the word-3 read data phase
    ahb_write(R_CTRL, 32'h06);
    repeat (10) @(negedge clk);
    ahb_read(R_STAT, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_status got=%h exp=0", rd);
    end
    ahb_read(R_CNT, rd);
    n_checks++;
    if (rd !== 32'd5) begin
      n_fail++;
      $display("FAIL abort_count got=%0d exp=5", rd);
    end
    ahb_read(R_SRC, rd);
    n_checks++;
    if (rd !== 32'h2000_000C) begin
      n_fail++;
      $display("FAIL abort_src got=%h exp=2000000c", rd);
    end
    ahb_read(R_CTRL, rd);
    n_checks++;
    if (rd !== 32'h06) begin
      n_fail++;
      $display("FAIL abort_ctrl got=%h exp=06", rd);
    end
    n_checks++;
    if (wr_cnt - wr0 != 3 || ns_cnt - ns0 != 6 || wmem[82] !== 32'h33) begin
      n_fail++;
      $display("FAIL abort_bus got=wr%0d ns%0d w3=%h exp=wr3 ns6 w3=33",
               wr_cnt - wr0, ns_cnt - ns0, wmem[82]);
    end
  endtask

  initial begin
    s_bus.HSEL = 1'b0; s_bus.HADDR = 32'h0; s_bus.HTRANS = 2'b00; s_bus.HSIZE = 3'b010;
    s_bus.HWRITE = 1'b0; s_bus.HREADY = 1'b1; s_bus.HWDATA = 32'h0;
    for (int i = 0; i < 256; i++) rmem[i] = 32'h0;
    for (int i = 0; i < 8; i++) rmem[i] = 32'(8'h11 * (i + 1));
    rmem[8] = 32'hDEAD_BEEF;

    test_reset();
    test_mem_copy();
    test_irq_clear();
    test_dreq_mode();
    test_count_zero();
    test_wait_states();
    test_abort();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
